// File: rtl/cu_scalar_out_buffer.sv
// Output FIFO between the ComputeUnit scalar result and the scalar interconnect.
// Optional zero-latency pass-through when empty: define SCALAR_OUT_BYPASS_EN.
module cu_scalar_out_buffer #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  input  logic                       in_done,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       drain_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stateT;

  stateT         state;
  stateT         nextState;
  logic [W:0]    mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [W:0]    head;
  logic          notEmpty;
  logic          push;
  logic          pop;
  logic          lastPop;
  logic          refused;

  assign head     = mem[rdPtr];
  assign notEmpty = (count != '0);

  always_comb begin
    in_ready = (count < FULL) && (state != DRAIN);
    push     = in_valid && in_ready;
    refused  = in_valid && !in_ready && (state != DRAIN);
`ifdef SCALAR_OUT_BYPASS_EN
    // An empty buffer outside a drain forwards the offered word straight through.
    out_valid = notEmpty || (in_valid && (state != DRAIN));
    if (notEmpty) begin
      out_data = head[W-1:0];
      out_last = head[W];
    end else if (in_valid && (state != DRAIN)) begin
      out_data = in_data;
      out_last = in_done;
    end else begin
      out_data = '0;
      out_last = 1'b0;
    end
`else
    out_valid = notEmpty;
    out_data  = notEmpty ? head[W-1:0] : '0;
    out_last  = notEmpty && head[W];
`endif
    pop     = out_valid && out_ready;
    lastPop = pop && out_last;
  end

  // Run tracking: a done-tagged word closes the run; its departure reopens input.
  always_comb begin
    nextState = state;
    if (push) begin
      if (in_done) begin
        nextState = DRAIN;
      end else if (state == IDLE) begin
        nextState = STREAM;
      end
    end
    if (lastPop) begin
      nextState = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state      <= nextState;
      drain_done <= lastPop;
      if (refused) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: an empty buffer never exposes its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {in_done, in_data};
    end
  end

endmodule

// File: tb/tb_cu_scalar_out_buffer.sv
// Self-checking bench for cu_scalar_out_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_cu_scalar_out_buffer;

  localparam int W     = 7;
  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic [W-1:0]               in_data;
  logic                       in_done;
  logic                       in_ready;
  logic                       out_valid;
  logic [W-1:0]               out_data;
  logic                       out_last;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic                       drain_done;

  int checks = 0;
  int errors = 0;

  logic [W:0] mq[$];
  bit         mDrain;
  bit         mOvf;
  bit         mDrainDone;
  bit         lastPush;

  cu_scalar_out_buffer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_done    (in_done),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit dn, input bit rdy);
    bit         expReady;
    bit         expValid;
    bit         expLast;
    bit         bypassWord;
    bit         doPush;
    bit         doPop;
    bit         doRefuse;
    logic [W-1:0] expData;
    logic [W:0] popped;
    in_valid  = v;
    in_data   = d;
    in_done   = dn;
    out_ready = rdy;
    #1;
    expReady   = (mq.size() < DEPTH) && !mDrain;
    bypassWord = 1'b0;
`ifdef SCALAR_OUT_BYPASS_EN
    bypassWord = (mq.size() == 0) && !mDrain && v;
`endif
    expValid = (mq.size() > 0) || bypassWord;
    if (mq.size() > 0) begin
      {expLast, expData} = mq[0];
    end else if (bypassWord) begin
      {expLast, expData} = {dn, d};
    end else begin
      {expLast, expData} = '0;
    end
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(expValid));
    checkOutput("out_data", 32'(out_data), 32'(expData));
    checkOutput("out_last", 32'(out_last), 32'(expLast));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("drain_done", 32'(drain_done), 32'(mDrainDone));
    doPush   = v && expReady;
    doPop    = expValid && rdy;
    doRefuse = v && !expReady && !mDrain;
    @(posedge clk);
    #1;
    if (doPush) begin
      mq.push_back({dn, d});
      if (dn) mDrain = 1'b1;
    end
    mDrainDone = 1'b0;
    if (doPop) begin
      popped = mq.pop_front();
      if (popped[W]) begin
        mDrain     = 1'b0;
        mDrainDone = 1'b1;
      end
    end
    if (doRefuse) mOvf = 1'b1;
    lastPush = doPush;
  endtask

  // Reset asserted mid-cycle must clear everything without waiting for an edge.
  task automatic doReset();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drain_done", 32'(drain_done), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    mDrain     = 1'b0;
    mOvf       = 1'b0;
    mDrainDone = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_done   = 1'b0;
    out_ready = 1'b0;
    mDrain     = 1'b0;
    mOvf       = 1'b0;
    mDrainDone = 1'b0;
    #3;
    checkOutput("init_out_valid", 32'(out_valid), 32'd0);
    checkOutput("init_count", 32'(count), 32'd0);
    checkOutput("init_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill to capacity, overflow on a fifth word, then drain in order.
    applyStimulus(1'b1, 7'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'h44, 1'b0, 1'b0);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 7'h55, 1'b0, 1'b0);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);
    doReset();

    // Simultaneous push and pop at count 2.
    applyStimulus(1'b1, 7'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'h7F, 1'b0, 1'b1);
    checkOutput("pp_count", 32'(count), 32'd2);
    checkOutput("pp_head", 32'(out_data), 32'h02);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);

    // Done-tagged word: input ignored while draining, then a one-cycle pulse.
    applyStimulus(1'b1, 7'h05, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 7'h66, 1'b0, 1'b0);
    checkOutput("drain_overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);
    checkOutput("drain_pulse", 32'(drain_done), 32'd1);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b0);

    // Pointer wrap: ten words with out_ready toggling each cycle.
    sent = 0;
    for (int cyc = 0; cyc < 60 && sent < 10; cyc++) begin
      applyStimulus((mq.size() < DEPTH) && !mDrain, W'(sent), 1'b0, 1'(cyc % 2));
      if (lastPush) sent++;
    end
    checkOutput("wrap_sent", 32'(sent), 32'd10);
    for (int i = 0; i < 20 && mq.size() > 0; i++) applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);
    checkOutput("wrap_count", 32'(count), 32'd0);
    checkOutput("wrap_overflow", 32'(overflow), 32'd0);

    // Asynchronous reset with words stored, then with a drain pulse pending.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'(7'h30 + i), 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 7'h05, 1'b1, 1'b0);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);
    checkOutput("pend_drain_done", 32'(drain_done), 32'(mDrainDone));
    doReset();
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b0);

    // Empty buffer with a ready consumer: bypass or one-cycle latency.
    applyStimulus(1'b1, 7'h2A, 1'b0, 1'b1);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
